// File: rtl/lives_ctrl_pkg.sv
// Shared types and widths for the lives controller: FSM encoding,
// life-count width and frame-counter width.
package lives_ctrl_pkg;

   localparam int LIFE_W = 4;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      ALIVE     = 2'd0,
      INVULN    = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

endpackage

// File: rtl/lives_ctrl_frame_tick.sv
// VGA frame tick: one-cycle pulse on a 0->1 transition of vsync.
// The delayed copy resets high so vsync already high at reset release is not a tick.
module frame_tick (
   input  logic pclk,
   input  logic rst,
   input  logic vsync_i,
   output logic tick_o
);

   logic vsync_dly_q;

   always_ff @(posedge pclk) begin
      if (rst) begin
         vsync_dly_q <= 1'b1;
      end else begin
         vsync_dly_q <= vsync_i;
      end
   end

   assign tick_o = vsync_i & ~vsync_dly_q;

endmodule

// File: rtl/lives_ctrl.sv
// Ship lives controller: counts lost lives, runs the post-hit invulnerability
// window with sprite blinking, and flags game over. All outputs registered.
module lives_ctrl
   import lives_ctrl_pkg::*;
#(
   parameter int N_LIVES       = 3,
   parameter int INVULN_FRAMES = 120,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              vsync_in,
   input  logic              hit,
   input  logic              restart,
   output logic [LIFE_W-1:0] dead_count,
   output logic              invuln,
   output logic              ship_visible,
   output logic              game_over
);

   localparam logic [LIFE_W-1:0] N_LIVES_C = LIFE_W'(N_LIVES);
   localparam logic [CNT_W-1:0]  INVULN_C  = CNT_W'(INVULN_FRAMES);
   localparam logic [CNT_W-1:0]  BLINK_C   = CNT_W'(BLINK_FRAMES);

   logic tick;

   state_t            state_q, state_d;
   logic [LIFE_W-1:0] dead_count_q, dead_count_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              invuln_q, invuln_d;
   logic              visible_q, visible_d;
   logic              game_over_q, game_over_d;

   frame_tick u_frame_tick (
      .pclk    (pclk),
      .rst     (rst),
      .vsync_i (vsync_in),
      .tick_o  (tick)
   );

   always_comb begin
      state_d      = state_q;
      dead_count_d = dead_count_q;
      frame_cnt_d  = frame_cnt_q;
      blink_cnt_d  = blink_cnt_q;
      invuln_d     = invuln_q;
      visible_d    = visible_q;
      game_over_d  = game_over_q;

      if (restart) begin
         // Restart overrides everything, including a coincident hit.
         state_d      = ALIVE;
         dead_count_d = '0;
         frame_cnt_d  = '0;
         blink_cnt_d  = '0;
         invuln_d     = 1'b0;
         visible_d    = 1'b1;
         game_over_d  = 1'b0;
      end else begin
         case (state_q)
            ALIVE: begin
               invuln_d    = 1'b0;
               visible_d   = 1'b1;
               game_over_d = 1'b0;
               // A coincident frame tick is deliberately not applied here,
               // so the freshly loaded counters start at full length.
               if (hit && (dead_count_q < N_LIVES_C)) begin
                  dead_count_d = dead_count_q + LIFE_W'(1);
                  visible_d    = 1'b0;
                  if (dead_count_d == N_LIVES_C) begin
                     state_d     = GAME_OVER;
                     game_over_d = 1'b1;
                  end else begin
                     state_d     = INVULN;
                     invuln_d    = 1'b1;
                     frame_cnt_d = INVULN_C;
                     blink_cnt_d = BLINK_C;
                  end
               end
            end
            INVULN: begin
               invuln_d = 1'b1;
               if (tick) begin
                  if (frame_cnt_q <= CNT_W'(1)) begin
                     state_d     = ALIVE;
                     invuln_d    = 1'b0;
                     visible_d   = 1'b1;
                     frame_cnt_d = '0;
                     blink_cnt_d = '0;
                  end else begin
                     frame_cnt_d = frame_cnt_q - CNT_W'(1);
                     // Counter reaching zero this tick: toggle and reload.
                     if (blink_cnt_q <= CNT_W'(1)) begin
                        visible_d   = ~visible_q;
                        blink_cnt_d = BLINK_C;
                     end else begin
                        blink_cnt_d = blink_cnt_q - CNT_W'(1);
                     end
                  end
               end
            end
            GAME_OVER: begin
               dead_count_d = N_LIVES_C;
               invuln_d     = 1'b0;
               visible_d    = 1'b0;
               game_over_d  = 1'b1;
            end
            default: begin
               state_d = ALIVE;
            end
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= ALIVE;
         dead_count_q <= '0;
         frame_cnt_q  <= '0;
         blink_cnt_q  <= '0;
         invuln_q     <= 1'b0;
         visible_q    <= 1'b1;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dead_count_q <= dead_count_d;
         frame_cnt_q  <= frame_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         invuln_q     <= invuln_d;
         visible_q    <= visible_d;
         game_over_q  <= game_over_d;
      end
   end

   assign dead_count   = dead_count_q;
   assign invuln       = invuln_q;
   assign ship_visible = visible_q;
   assign game_over    = game_over_q;

endmodule

// File: tb/tb_lives_ctrl.sv
// Directed bench for lives_ctrl with N_LIVES=3, INVULN_FRAMES=4, BLINK_FRAMES=2.
module tb_lives_ctrl;

   logic       pclk = 1'b0;
   logic       rst;
   logic       vsync_in;
   logic       hit;
   logic       restart;
   logic [3:0] dead_count;
   logic       invuln;
   logic       ship_visible;
   logic       game_over;

   int tests  = 0;
   int failed = 0;

   lives_ctrl #(
      .N_LIVES       (3),
      .INVULN_FRAMES (4),
      .BLINK_FRAMES  (2)
   ) dut (
      .pclk         (pclk),
      .rst          (rst),
      .vsync_in     (vsync_in),
      .hit          (hit),
      .restart      (restart),
      .dead_count   (dead_count),
      .invuln       (invuln),
      .ship_visible (ship_visible),
      .game_over    (game_over)
   );

   always #5 pclk = ~pclk;

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   // One frame tick: a low cycle, then the rising edge sampled on the next clock.
   task automatic tick();
      vsync_in = 1'b0;
      cyc();
      vsync_in = 1'b1;
      cyc();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] dc, input logic inv,
                          input logic vis, input logic go);
      chk({tag, ".dead"}, {4'h0, dead_count}, {4'h0, dc});
      chk({tag, ".invuln"}, {7'h0, invuln}, {7'h0, inv});
      chk({tag, ".visible"}, {7'h0, ship_visible}, {7'h0, vis});
      chk({tag, ".game_over"}, {7'h0, game_over}, {7'h0, go});
      $display("[TB] %s: dead=%0d invuln=%0b visible=%0b game_over=%0b", tag,
               dead_count, invuln, ship_visible, game_over);
   endtask

   initial begin
      rst = 1'b1; vsync_in = 1'b1; hit = 1'b0; restart = 1'b0;
      cyc(); cyc();
      chk_all("reset", 4'd0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      cyc();
      chk_all("post_reset", 4'd0, 1'b0, 1'b1, 1'b0);

      // Single hit pulse, blink after 2 ticks, ALIVE after the 4th tick.
      vsync_in = 1'b0; cyc();
      hit = 1'b1; cyc(); hit = 1'b0;
      chk_all("hit1", 4'd1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("hit1.tick1", 4'd1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("hit1.tick2", 4'd1, 1'b1, 1'b1, 1'b0);
      hit = 1'b1; cyc(); hit = 1'b0;
      chk_all("hit1.ignored", 4'd1, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("hit1.tick3", 4'd1, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("hit1.tick4", 4'd1, 1'b0, 1'b1, 1'b0);

      // Restart back to zero lives lost.
      restart = 1'b1; cyc(); restart = 1'b0;
      chk_all("restart", 4'd0, 1'b0, 1'b1, 1'b0);

      // Held hit: one life per ALIVE entry.
      hit = 1'b1; cyc();
      chk_all("held.entry", 4'd1, 1'b1, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk_all("held.tick3", 4'd1, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("held.tick4", 4'd1, 1'b0, 1'b1, 1'b0);
      cyc();
      chk_all("held.realive", 4'd2, 1'b1, 1'b0, 1'b0);
      hit = 1'b0;

      // Third hit ends the game; later hits and ticks change nothing.
      tick(); tick(); tick(); tick();
      chk_all("go.alive", 4'd2, 1'b0, 1'b1, 1'b0);
      hit = 1'b1; cyc(); hit = 1'b0;
      chk_all("go.enter", 4'd3, 1'b0, 1'b0, 1'b1);
      hit = 1'b1; cyc(); hit = 1'b0;
      chk_all("go.extra_hit", 4'd3, 1'b0, 1'b0, 1'b1);
      tick();
      chk_all("go.tick", 4'd3, 1'b0, 1'b0, 1'b1);

      // Restart and hit together: restart wins.
      restart = 1'b1; hit = 1'b1; cyc(); restart = 1'b0; hit = 1'b0;
      chk_all("restart_hit", 4'd0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk_all("restart_hit.next", 4'd0, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of INVULN with vsync high.
      hit = 1'b1; cyc(); hit = 1'b0;
      tick();
      chk_all("rst.invuln", 4'd1, 1'b1, 1'b0, 1'b0);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk_all("rst.mid", 4'd0, 1'b0, 1'b1, 1'b0);
      hit = 1'b1; cyc(); hit = 1'b0;
      cyc(); cyc(); cyc();
      chk_all("rst.no_tick", 4'd1, 1'b1, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk_all("rst.tick3", 4'd1, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("rst.tick4", 4'd1, 1'b0, 1'b1, 1'b0);

      // Hit coincident with a vsync rising edge: full window still applies.
      vsync_in = 1'b0; cyc();
      vsync_in = 1'b1; hit = 1'b1; cyc(); hit = 1'b0;
      chk_all("coll.entry", 4'd2, 1'b1, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk_all("coll.tick3", 4'd2, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("coll.tick4", 4'd2, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/lives_ctrl.md
LIVES_CTRL -- requirements
Module: lives_ctrl

Interface
REQ-001 Parameter N_LIVES, default 3: lives per game, range 1..15.
REQ-002 Parameter INVULN_FRAMES, default 120: post-hit invulnerability length in frames, range 1..255.
REQ-003 Parameter BLINK_FRAMES, default 8: frames per blink half-period during invulnerability, range 1..255.
REQ-004 pclk  in  1  pixel clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 vsync_in  in  1  VGA vertical sync; a frame tick is its 0->1 transition.
REQ-007 hit  in  1  collision indication from the ship/enemy-bullet collision logic; level or pulse accepted.
REQ-008 restart  in  1  new-game request, single-cycle pulse.
REQ-009 dead_count  out  4  lives lost so far; feeds the lives-icon overlay.
REQ-010 invuln  out  1  high while hits are ignored after a loss.
REQ-011 ship_visible  out  1  ship sprite enable, used for blinking.
REQ-012 game_over  out  1  high when all lives are lost.

Function
REQ-013 All outputs SHALL be registered; a qualifying hit at cycle t SHALL be reflected on the outputs at t+1.
REQ-014 Frame tick SHALL be vsync_in high AND registered vsync_d low; vsync_d updates every cycle.
REQ-015 The FSM SHALL have three states: ALIVE, INVULN and GAME_OVER.
REQ-016 In ALIVE with hit=1, dead_count SHALL increment by 1.
REQ-017 On that hit, the next state SHALL be GAME_OVER if the new count equals N_LIVES; otherwise it SHALL be INVULN.
REQ-018 On entry to INVULN, frame_cnt SHALL load INVULN_FRAMES, blink_cnt SHALL load BLINK_FRAMES, and ship_visible SHALL go 0.
REQ-019 In INVULN, hit SHALL be ignored.
REQ-020 In INVULN, each frame tick SHALL decrement frame_cnt and blink_cnt.
REQ-021 In INVULN, when blink_cnt reaches 0, ship_visible SHALL toggle and blink_cnt SHALL reload BLINK_FRAMES.
REQ-022 In INVULN, a frame tick with frame_cnt==1 SHALL transition to ALIVE. Exactly INVULN_FRAMES ticks are spent in INVULN.
REQ-023 ALIVE SHALL drive ship_visible=1 and invuln=0.
REQ-024 INVULN SHALL drive invuln=1.
REQ-025 GAME_OVER SHALL drive ship_visible=0, invuln=0 and game_over=1.
REQ-026 In GAME_OVER, dead_count SHALL hold at N_LIVES and hit SHALL be ignored.
REQ-027 In any state, restart=1 SHALL set dead_count=0, go to ALIVE, clear both counters, and drive ship_visible=1 next cycle.
REQ-028 Simultaneous restart and hit: restart SHALL win and the hit SHALL be dropped.
REQ-029 Simultaneous hit and frame tick in ALIVE: the hit SHALL be processed, and the tick SHALL not decrement the freshly loaded counters.
REQ-030 A held hit level SHALL cost exactly one life per entry into ALIVE; a hit still high when INVULN expires SHALL cost another life on the first ALIVE cycle.
REQ-031 dead_count SHALL never exceed N_LIVES.
REQ-032 Counters SHALL be 8 bits and SHALL not wrap below 0.

Reset
REQ-033 When rst=1, the next edge SHALL set: state=ALIVE, dead_count=0, invuln=0, ship_visible=1, game_over=0, frame_cnt=0, blink_cnt=0, vsync_d=1.
REQ-034 Because vsync_d resets to 1, no spurious frame tick SHALL occur when vsync_in is high at reset release.
REQ-035 rst asserted mid-INVULN or in GAME_OVER SHALL abort the operation with no residual state.

Structure
REQ-036 A shared package SHALL hold the state encoding (ALIVE=2'd0, INVULN=2'd1, GAME_OVER=2'd2), the 4-bit life-count width and the 8-bit frame-counter width.
REQ-037 One sub-module, frame_tick, SHALL hold the vsync rising-edge detector with its own synchronous reset to 1.
REQ-038 The FSM and counters SHALL be in lives_ctrl using the registered state plus combinational next-state pattern.

Verification
REQ-039 Scenario single hit: N_LIVES=3, INVULN_FRAMES=4, BLINK_FRAMES=2, one hit pulse in ALIVE -> next cycle dead_count=1, invuln=1, ship_visible=0; ship_visible toggles after 2 ticks; ALIVE after the 4th tick.
REQ-040 Scenario ignored hits: hit held high 10 frames with INVULN_FRAMES=4 -> dead_count=1 during INVULN, becomes 2 on the first ALIVE cycle.
REQ-041 Scenario game over: 3 spaced hits -> dead_count=3, game_over=1, ship_visible=0; a further hit leaves dead_count=3.
REQ-042 Scenario restart priority: restart and hit in the same cycle while in GAME_OVER -> dead_count=0, ALIVE, game_over=0.
REQ-043 Scenario reset safety: rst mid-INVULN with vsync_in high -> ALIVE, dead_count=0; no tick counted until vsync_in falls and rises.
REQ-044 Scenario tick collision: hit coincident with a vsync rising edge -> frame_cnt=INVULN_FRAMES after the edge, not INVULN_FRAMES-1.
